axi_lite_led_pwm: RTL
=====================

// Module: axi_lite_led_pwm
// PURPOSE
//   AXI4-Lite slave register bank driving N_CH LED/GPIO outputs, each with its own PWM duty.
//   Next generation of the fixed 8-bit LED register: width, channel count and PWM resolution are parameters.
//   Sits on an interconnect master port of the PS block design and drives led_o directly.
// PARAMETERS
//   C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 is supported.
//   C_S_AXI_ADDR_WIDTH  8   AXI address width; must be >= 2+clog2(4+N_CH).
//   N_CH                8   number of PWM output channels, 1..32.
//   PWM_BITS            8   PWM counter width; duty registers are PWM_BITS+1 wide.
//   PRESCALE_W          16  prescaler width.
// PORTS
//   S_AXI_ACLK     in   1         AXI clock; the only clock.
//   S_AXI_ARESETn  in   1         asynchronous, active-low reset.
//   S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY  standard AXI4-Lite write address and data channels.
//   S_AXI_BRESP/BVALID/BREADY                                            standard AXI4-Lite write response channel.
//   S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY standard AXI4-Lite read channels.
//   AWPROT and ARPROT are ignored.
//   led_o          out  N_CH      registered PWM outputs.
// BEHAVIOUR
//   Reset: all AXI outputs 0, led_o 0, all registers 0 (PRESCALE 0 = one tick per clock).
//   Reset mid-transaction: handshakes drop immediately and pending B/R responses are discarded.
//   Register map (byte offsets; ADDR[1:0] ignored):
//     0x00 CTRL      RW  bit0 EN; 0 forces led_o to 0 and holds both counters at 0.
//     0x04 PRESCALE  RW  [PRESCALE_W-1:0].
//     0x08 STATUS    RO  [N_CH-1:0] current led_o.
//     0x0C BLINK     RW  present only with the macro.
//     0x10+4*i DUTY[i]  RW  [PWM_BITS:0].
//   Unmapped or RO writes: ignored, BRESP=SLVERR(2'b10). Unmapped reads: RDATA=0, RRESP=SLVERR. Otherwise OKAY.
//   Write path:
//     - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
//     - The register updates on that edge, byte-wise per WSTRB.
//     - BVALID rises on the next cycle and holds until BREADY.
//     - A write completes in 2 cycles minimum; the next write is accepted no earlier than the cycle after the B handshake.
//   Read path:
//     - ARREADY pulses one cycle when ARVALID & !RVALID.
//     - RDATA/RRESP are registered; RVALID is high the next cycle and holds, with stable data, until RREADY.
//   Same-edge read and write to one register: the read returns the pre-write value.
//   PWM:
//     - Prescaler counts 0..PRESCALE and emits a tick on reaching PRESCALE, then wraps to 0.
//     - pwm_cnt (PWM_BITS wide) increments per tick and wraps 2^PWM_BITS-1 -> 0.
//     - DUTY writes go to a shadow register, copied to active duty only on the tick that wraps pwm_cnt to 0 (glitch-free).
//     - If EN is 0, the shadow is copied every cycle.
//     - led_o[i] <= EN & (pwm_cnt < duty_act[i]), one-cycle latency.
//     - Duty 0 = always off; duty >= 2^PWM_BITS = always on.
//   PRESCALE written below the current prescaler count: the count wraps at its maximum and restarts at 0 (no lockup).
// CONFIGURATION
//   LED_PWM_BLINK_EN defined:
//     - BLINK at 0x0C: [N_CH-1:0] mask, [31:24] period exponent P.
//     - A 24-bit free-running tick counter runs; masked channels are ANDed with tick_cnt[P] (P>23 treated as 23).
//   LED_PWM_BLINK_EN undefined:
//     - 0x0C is unmapped (SLVERR); no blink logic is built.
// STRUCTURE
//   Package led_pwm_pkg:
//     - register offsets (ADDR_CTRL, ADDR_PRESCALE, ADDR_STATUS, ADDR_BLINK, ADDR_DUTY0).
//     - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
//   Sub-module led_pwm_core: prescaler, pwm_cnt, shadow/active duty and comparators; AXI logic stays in this top.
// TESTING
//   1. Reset with AWVALID held: all outputs 0; after release, write CTRL=1 -> BVALID 2 cycles after AW/W, BRESP=00.
//   2. PRESCALE=0, DUTY0=64, EN=1, PWM_BITS=8 -> led_o[0] high 64 of every 256 cycles; DUTY0=256 -> constantly high.
//   3. Change DUTY0 64->192 mid-period -> pulse width changes only at the next pwm_cnt wrap.
//   4. Read 0x08 with RREADY low for 5 cycles -> RVALID/RDATA stable; read 0xFC -> RDATA=0, RRESP=10.
//   5. Write 0x08 or an unmapped address -> BRESP=10, no register changes; WSTRB=0001 to DUTY0 -> only byte 0 updates.
//   6. With LED_PWM_BLINK_EN, BLINK mask=1, P=4, DUTY0=256 -> led_o[0] toggles every 16 ticks; without it, BLINK write -> SLVERR.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: register map, response codes and write-strobe merge for the LED PWM block
package led_pwm_pkg;
  localparam logic [31:0] ADDR_CTRL     = 32'h00;
  localparam logic [31:0] ADDR_PRESCALE = 32'h04;
  localparam logic [31:0] ADDR_STATUS   = 32'h08;
  localparam logic [31:0] ADDR_BLINK    = 32'h0C;
  localparam logic [31:0] ADDR_DUTY0    = 32'h10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/axi_lite_led_pwm_if.sv
// axi_lite_led_pwm_if: AXI4-Lite bus bundle for the LED PWM register bank
interface axi_lite_led_pwm_if #(parameter int ADDR_W = 8, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  modport master(
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave(
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/led_pwm_core.sv
// led_pwm_core: prescaler, PWM counter, shadow/active duty and per-channel comparators
// LED_PWM_BLINK_EN adds the 24-bit tick counter used to gate masked channels.
module led_pwm_core
  import led_pwm_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [PRESCALE_W-1:0]          prescale,
  input  logic [N_CH-1:0]                duty_we,
  input  logic [PWM_BITS:0]              duty_wd,
`ifdef LED_PWM_BLINK_EN
  input  logic [N_CH-1:0]                blink_mask,
  input  logic [7:0]                     blink_p,
`endif
  output logic [N_CH-1:0][PWM_BITS:0]    duty_sh,
  output logic [N_CH-1:0]                led
);
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_CH-1:0][PWM_BITS:0] duty_act;
  logic [N_CH-1:0] gate;
  logic tick, wrap;
  // equality compare lets a shrunken PRESCALE run the count to its natural wrap
  assign tick = pre_cnt == prescale;
  assign wrap = tick && pwm_cnt == '1;
`ifdef LED_PWM_BLINK_EN
  logic [23:0] tick_cnt;
  logic [4:0] bit_sel;
  assign bit_sel = blink_p > 8'd23 ? 5'd23 : blink_p[4:0];
  assign gate = ~blink_mask | {N_CH{tick_cnt[bit_sel]}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tick_cnt <= '0;
    else if (en && tick) tick_cnt <= tick_cnt + 1'b1;
`else
  assign gate = '1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      duty_sh  <= '0;
      duty_act <= '0;
      led      <= '0;
    end else begin
      pre_cnt <= !en || tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= !en ? '0 : pwm_cnt + PWM_BITS'(tick);
      for (int i = 0; i < N_CH; i++) begin
        if (duty_we[i]) duty_sh[i] <= duty_wd;
        if (!en || wrap) duty_act[i] <= duty_sh[i];
        led[i] <= en && gate[i] && ({1'b0, pwm_cnt} < duty_act[i]);
      end
    end
endmodule

// File: rtl/axi_lite_led_pwm.sv
// axi_lite_led_pwm: AXI4-Lite register bank driving N_CH PWM LED outputs
// Define LED_PWM_BLINK_EN to map BLINK at 0x0C and build the blink gating.
module axi_lite_led_pwm
  import led_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_CH               = 8,
  parameter int PWM_BITS           = 8,
  parameter int PRESCALE_W         = 16
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETn,
  axi_lite_led_pwm_if.slave      s_axi,
  output logic [N_CH-1:0]        led_o
);
  logic en, wr, rd, aw_go, w_hit, w_ok, r_ok, unused;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0] w_a, r_a, w_old, w_new, r_val;
  logic [N_CH-1:0] duty_we;
  logic [N_CH-1:0][PWM_BITS:0] duty_sh;
`ifdef LED_PWM_BLINK_EN
  logic [N_CH-1:0] blink_mask;
  logic [7:0] blink_p;
`endif
  function automatic logic [32:0] reg_rd(input logic [31:0] a);
    logic [32:0] r;
    r = '0;
    if (a == ADDR_CTRL) r = {1'b1, 31'b0, en};
    else if (a == ADDR_PRESCALE) r = {1'b1, 32'(prescale)};
    else if (a == ADDR_STATUS) r = {1'b1, 32'(led_o)};
`ifdef LED_PWM_BLINK_EN
    else if (a == ADDR_BLINK) r = {1'b1, 32'(blink_mask) | {blink_p, 24'b0}};
`endif
    for (int i = 0; i < N_CH; i++) if (a == ADDR_DUTY0 + 32'(4*i)) r = {1'b1, 32'(duty_sh[i])};
    return r;
  endfunction
  assign w_a = 32'(s_axi.awaddr) & ~32'h3;
  assign r_a = 32'(s_axi.araddr) & ~32'h3;
  assign wr = s_axi.awready && s_axi.awvalid && s_axi.wvalid;
  assign rd = s_axi.arready && s_axi.arvalid;
  assign aw_go = s_axi.awvalid && s_axi.wvalid && !s_axi.bvalid && !s_axi.awready;
  assign unused = ^{s_axi.awprot, s_axi.arprot, w_new};
  always_comb begin
    {w_hit, w_old} = reg_rd(w_a);
    {r_ok, r_val} = reg_rd(r_a);
    w_ok = w_hit && w_a != ADDR_STATUS;
    w_new = strb_merge(w_old, s_axi.wdata, s_axi.wstrb);
    for (int i = 0; i < N_CH; i++) duty_we[i] = wr && w_a == ADDR_DUTY0 + 32'(4*i);
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn)
    if (!S_AXI_ARESETn) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      en            <= 1'b0;
      prescale      <= '0;
`ifdef LED_PWM_BLINK_EN
      blink_mask    <= '0;
      blink_p       <= '0;
`endif
    end else begin
      s_axi.awready <= aw_go;
      s_axi.wready  <= aw_go;
      if (wr) begin
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi.bready) s_axi.bvalid <= 1'b0;
      if (wr && w_a == ADDR_CTRL) en <= w_new[0];
      if (wr && w_a == ADDR_PRESCALE) prescale <= w_new[PRESCALE_W-1:0];
`ifdef LED_PWM_BLINK_EN
      if (wr && w_a == ADDR_BLINK) begin
        blink_mask <= w_new[N_CH-1:0];
        blink_p    <= w_new[31:24];
      end
`endif
      s_axi.arready <= s_axi.arvalid && !s_axi.rvalid && !s_axi.arready;
      // register values are sampled before this edge's write lands
      if (rd) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= r_val;
        s_axi.rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi.rready) s_axi.rvalid <= 1'b0;
    end
  led_pwm_core #(.N_CH(N_CH), .PWM_BITS(PWM_BITS), .PRESCALE_W(PRESCALE_W)) u_core (
    .clk        (S_AXI_ACLK),
    .rst_n      (S_AXI_ARESETn),
    .en         (en),
    .prescale   (prescale),
    .duty_we    (duty_we),
    .duty_wd    (w_new[PWM_BITS:0]),
`ifdef LED_PWM_BLINK_EN
    .blink_mask (blink_mask),
    .blink_p    (blink_p),
`endif
    .duty_sh    (duty_sh),
    .led        (led_o)
  );
endmodule
